axi2per_req_arbiter: RTL

Request-side arbiter for the AXI-to-peripheral bridge: selects between a pending AXI read and a pending AXI write, drives a single transaction at a time onto the peripheral interconnect master port, and hands its attributes to the response channel. It sits between the AR and AW/W channel front-ends and the response channel. It keeps exactly one transaction in flight, and issues the next only after the response channel reports the current one retired.

---
 rtl/axi2per_req_arbiter_if.sv | 40 ++++
 rtl/axi2per_req_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/axi2per_req_arbiter_if.sv
// Request-side bus bundle for axi2per_req_arbiter: AR/AW front-ends, peripheral
// master port and response-channel handoff. master = arbiter, slave = environment.
interface axi2per_req_arbiter_if #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3
);
    logic                      rd_req_i;
    logic [AXI_ID_WIDTH-1:0]   rd_id_i;
    logic [AXI_ADDR_WIDTH-1:0] rd_add_i;
    logic                      rd_gnt_o;
    logic                      wr_req_i;
    logic [AXI_ID_WIDTH-1:0]   wr_id_i;
    logic [AXI_ADDR_WIDTH-1:0] wr_add_i;
    logic                      wr_gnt_o;
    logic                      per_master_req_o;
    logic [PER_ADDR_WIDTH-1:0] per_master_add_o;
    logic                      per_master_we_o;
    logic                      per_master_gnt_i;
    logic                      trans_req_o;
    logic                      trans_we_o;
    logic [AXI_ID_WIDTH-1:0]   trans_id_o;
    logic [AXI_ADDR_WIDTH-1:0] trans_add_o;
    logic                      trans_r_valid_i;
    logic                      busy_o;

    modport master (
        input  rd_req_i, rd_id_i, rd_add_i, wr_req_i, wr_id_i, wr_add_i,
               per_master_gnt_i, trans_r_valid_i,
        output rd_gnt_o, wr_gnt_o, per_master_req_o, per_master_add_o, per_master_we_o,
               trans_req_o, trans_we_o, trans_id_o, trans_add_o, busy_o
    );

    modport slave (
        output rd_req_i, rd_id_i, rd_add_i, wr_req_i, wr_id_i, wr_add_i,
               per_master_gnt_i, trans_r_valid_i,
        input  rd_gnt_o, wr_gnt_o, per_master_req_o, per_master_add_o, per_master_we_o,
               trans_req_o, trans_we_o, trans_id_o, trans_add_o, busy_o
    );
endinterface

// File: rtl/axi2per_req_arbiter.sv
// Read/write request arbiter: one peripheral transaction in flight at a time.
// Define AXI2PER_WRITE_PRIO_EN for fixed write priority instead of round-robin.
module axi2per_req_arbiter #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    axi2per_req_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

    state_t                    state;
    logic                      sel_we;   // 1 = read, interconnect encoding
    logic [AXI_ID_WIDTH-1:0]   sel_id;
    logic [AXI_ADDR_WIDTH-1:0] sel_add;
    logic                      pick_rd;
    logic                      granted;

`ifdef AXI2PER_WRITE_PRIO_EN
    assign pick_rd = bus.rd_req_i && !bus.wr_req_i;
`else
    logic last_rd;
    // On a tie, alternate away from whichever direction issued last.
    assign pick_rd = bus.rd_req_i && (!bus.wr_req_i || !last_rd);
`endif

    assign granted = (state == REQ) && bus.per_master_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            sel_we  <= 1'b0;
            sel_id  <= '0;
            sel_add <= '0;
`ifndef AXI2PER_WRITE_PRIO_EN
            last_rd <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_req_i || bus.wr_req_i) begin
                        sel_we  <= pick_rd;
                        sel_id  <= pick_rd ? bus.rd_id_i  : bus.wr_id_i;
                        sel_add <= pick_rd ? bus.rd_add_i : bus.wr_add_i;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.per_master_gnt_i) begin
`ifndef AXI2PER_WRITE_PRIO_EN
                        last_rd <= sel_we;
`endif
                        state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.trans_r_valid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.per_master_req_o = (state == REQ);
    assign bus.per_master_add_o = sel_add[PER_ADDR_WIDTH-1:0];
    assign bus.per_master_we_o  = sel_we;
    assign bus.busy_o           = (state != IDLE);

    // Grant pulses follow the interconnect grant combinationally while in REQ.
    assign bus.trans_req_o      = granted;
    assign bus.rd_gnt_o         = granted && sel_we;
    assign bus.wr_gnt_o         = granted && !sel_we;

    assign bus.trans_we_o       = sel_we;
    assign bus.trans_id_o       = sel_id;
    assign bus.trans_add_o      = sel_add;
endmodule
